// File: rtl/pcw_vid_pkg.sv
// pcw_vid_pkg: video memory slot phases and timing constants shared with video_controller
package pcw_vid_pkg;
   typedef enum logic [1:0] {VID_ADDR, VID_DATA, CPU_ADDR, CPU_DATA} vmem_phase_t;
   localparam int PIX_DIV = 4;
   localparam int VID_ADDR_W = 17;
endpackage

// File: rtl/video_mem_responder.sv
// video_mem_responder: time-slices one video RAM between pixel fetches (phases 0-1) and CPU accesses (phases 2-3)
module video_mem_responder
   import pcw_vid_pkg::*;
#(
   parameter int ADDR_W = VID_ADDR_W,
   parameter int DATA_W = 8
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ce_pix,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_din,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q,
   output logic              sync_err
);
   logic [1:0] rst_q;
   logic rst_n_s;
   vmem_phase_t phase, phase_nxt;
   logic busy, issue;

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) rst_q <= '0;
      else rst_q <= {rst_q[0], 1'b1};
   assign rst_n_s = rst_q[1];

   // an early ce_pix in phase 2 withholds the CPU slot, so an access is never split by a resync
   always_comb begin
      phase_nxt = (ce_pix || phase == vmem_phase_t'(2'(PIX_DIV - 1))) ? VID_ADDR : vmem_phase_t'(phase + 2'd1);
      issue = phase == CPU_ADDR && cpu_req && !busy && !ce_pix;
   end

   always_ff @(posedge clk_sys or negedge rst_n_s)
      if (!rst_n_s) phase <= VID_ADDR;
      else phase <= phase_nxt;

   always_ff @(posedge clk_sys or negedge rst_n_s)
      if (!rst_n_s) begin
         vid_din <= '0;
         cpu_rdata <= '0;
         cpu_ack <= 1'b0;
         ram_addr <= '0;
         ram_we <= 1'b0;
         ram_wdata <= '0;
         sync_err <= 1'b0;
         busy <= 1'b0;
      end else begin
         cpu_ack <= busy && phase == CPU_DATA;
         sync_err <= ce_pix && phase != CPU_DATA;
         if (phase == VID_ADDR) begin
            ram_addr <= vid_addr;
            ram_we <= 1'b0;
         end
         if (phase == VID_DATA) vid_din <= ram_q;
         if (issue) begin
            ram_addr <= cpu_addr;
            ram_we <= cpu_we;
            ram_wdata <= cpu_wdata;
            busy <= 1'b1;
         end
         if (phase == CPU_DATA) begin
            ram_we <= 1'b0;
            busy <= 1'b0;
            if (busy && !ram_we) cpu_rdata <= ram_q;
         end
      end
endmodule

// File: tb/tb_video_mem_responder.sv
// tb_video_mem_responder: directed and random checks against a window-level memory model
module tb_video_mem_responder;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   logic ce_pix = 1'b0;
   logic [16:0] vid_addr = '0;
   logic [7:0] vid_din;
   logic cpu_req = 1'b0;
   logic cpu_we = 1'b0;
   logic [16:0] cpu_addr = '0;
   logic [7:0] cpu_wdata = '0;
   logic [7:0] cpu_rdata;
   logic cpu_ack;
   logic [16:0] ram_addr;
   logic ram_we;
   logic [7:0] ram_wdata;
   logic [7:0] ram_q;
   logic sync_err;

   logic [7:0] mem [0:131071];
   logic [7:0] ref_mem [0:131071];

   int checks = 0, errors = 0;
   int cyc = 0, ph = 0, gcyc = -100, rcyc = 0, ack_cyc = 0, n_ack = 0;
   logic req_active = 1'b0, t_we = 1'b0;
   logic [16:0] t_addr = '0, va = '0;
   logic [7:0] t_wdata = '0, old_val = '0, pend_rd = '0;
   logic [7:0] exp_vid = '0, exp_rd = '0;
   logic exp_sync = 1'b0;

   video_mem_responder dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .vid_addr(vid_addr), .vid_din(vid_din),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_q(ram_q), .sync_err(sync_err)
   );

   always #8 clk_sys = ~clk_sys;

   assign ram_q = mem[ram_addr];
   always @(posedge clk_sys) if (ram_we) mem[ram_addr] <= ram_wdata;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [16:0] pick();
      case ($urandom_range(0, 3))
         0: return 17'h01234;
         1: return 17'h00100;
         2: return 17'h1FFFF;
         default: return 17'($urandom_range(0, 63));
      endcase
   endfunction

   task automatic req(input logic we, input logic [16:0] a, input logic [7:0] d);
      t_we = we; t_addr = a; t_wdata = d;
      cpu_we = we; cpu_addr = a; cpu_wdata = d;
      cpu_req = 1'b1; req_active = 1'b1; rcyc = cyc;
   endtask

   // one clk_sys: model decides from this cycle's inputs, then outputs after the edge are checked
   task automatic tick();
      int nph;
      logic [7:0] nvid;
      logic nsync;
      if (ph == 0) va = vid_addr;
      nvid = (ph == 1) ? ref_mem[va] : exp_vid;
      nsync = ce_pix && ph != 3;
      if (ph == 2 && cpu_req && !ce_pix) begin
         gcyc = cyc;
         old_val = ref_mem[t_addr];
         if (t_we) ref_mem[t_addr] = t_wdata;
         else pend_rd = ref_mem[t_addr];
      end
      nph = (ce_pix || ph == 3) ? 0 : ph + 1;
      @(posedge clk_sys); #1;
      cyc++; ph = nph; exp_vid = nvid; exp_sync = nsync;
      if (cyc == gcyc + 2 && !t_we) exp_rd = pend_rd;
      chk("vid_din", int'(vid_din), int'(exp_vid));
      chk("sync_err", int'(sync_err), int'(exp_sync));
      chk("cpu_ack", int'(cpu_ack), int'(cyc == gcyc + 2));
      chk("ram_we", int'(ram_we), int'(cyc == gcyc + 1 && t_we));
      chk("cpu_rdata", int'(cpu_rdata), int'(exp_rd));
      if (cyc == gcyc + 1 && t_we) begin
         chk("ram_addr", int'(ram_addr), int'(t_addr));
         chk("ram_wdata", int'(ram_wdata), int'(t_wdata));
      end
      if (cpu_ack) begin
         n_ack++; ack_cyc = cyc; cpu_req = 1'b0; req_active = 1'b0;
      end
      ce_pix = ph == 3;
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 20 && req_active; i++) tick();
      if (req_active) begin
         chk("ack_timeout", 0, 1);
         cpu_req = 1'b0; req_active = 1'b0;
      end
   endtask

   task automatic goto_phase(input int p);
      for (int i = 0; i < 8 && ph != p; i++) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; cpu_req = 1'b0; ce_pix = 1'b0; req_active = 1'b0; gcyc = -100;
      repeat (3) begin
         @(posedge clk_sys); #1;
         chk("rst_ack", int'(cpu_ack), 0);
      end
      chk("rst_vid_din", int'(vid_din), 0);
      chk("rst_rdata", int'(cpu_rdata), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_ram_wdata", int'(ram_wdata), 0);
      chk("rst_sync_err", int'(sync_err), 0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      ph = 0; exp_vid = '0; exp_sync = 1'b0; exp_rd = '0;
   endtask

   initial begin
      int a0;
      for (int i = 0; i < 131072; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[17'h01234] = 8'hA5; ref_mem[17'h01234] = 8'hA5;
      mem[17'h00100] = 8'h11; ref_mem[17'h00100] = 8'h11;
      do_reset();

      vid_addr = 17'h01234;
      tick(); tick();
      chk("vid_a5", int'(vid_din), 8'hA5);
      tick(); tick();
      chk("vid_hold", int'(vid_din), 8'hA5);

      req(1'b1, 17'h1FFFF, 8'h3C);
      wait_ack();
      chk("wr_lat", ack_cyc - rcyc, 4);
      vid_addr = 17'h1FFFF;
      tick(); tick();
      chk("vid_3c", int'(vid_din), 8'h3C);

      goto_phase(3);
      req(1'b0, 17'h1FFFF, 8'h00);
      wait_ack();
      chk("rd_lat", ack_cyc - rcyc, 5);
      chk("rd_3c", int'(cpu_rdata), 8'h3C);

      goto_phase(0);
      vid_addr = 17'h00100;
      req(1'b1, 17'h00100, 8'h22);
      tick(); tick();
      chk("coll_old", int'(vid_din), 8'h11);
      wait_ack();
      tick(); tick();
      chk("coll_new", int'(vid_din), 8'h22);

      goto_phase(0);
      req(1'b0, 17'h01234, 8'h00);
      tick();
      ce_pix = 1'b1;
      a0 = n_ack;
      tick();
      chk("inj_sync", int'(sync_err), 1);
      tick();
      chk("inj_sync_pulse", int'(sync_err), 0);
      repeat (12) tick();
      chk("inj_ack_once", n_ack - a0, 1);
      chk("inj_rdata", int'(cpu_rdata), 8'hA5);

      goto_phase(0);
      req(1'b1, 17'h00020, 8'h5A);
      for (int i = 0; i < 8 && cyc != gcyc + 1; i++) tick();
      chk("midwr_we_high", int'(ram_we), 1);
      #2 reset_n = 1'b0;
      #1 chk("midwr_we_drop", int'(ram_we), 0);
      ref_mem[t_addr] = old_val;
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         vid_addr = pick();
         if (!req_active && $urandom_range(0, 2) == 0) req(1'($urandom_range(0, 1)), pick(), 8'($urandom));
         if ($urandom_range(0, 40) == 0) ce_pix = 1'b1;
         tick();
         if (req_active && cyc - rcyc > 30) begin
            chk("cpu_timeout", 0, 1);
            cpu_req = 1'b0; req_active = 1'b0;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
